// File: rtl/sha256xmss_host_regs_if.sv
//------------------------------------------------------------------------------
// Module  : sha256xmss_host_regs_if
// Brief   : Word-addressed host register bus, single-cycle read latency.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sha256xmss_host_regs_if;
  logic        bus_sel;
  logic        bus_we;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/sha256xmss_host_regs.sv
//------------------------------------------------------------------------------
// Module  : sha256xmss_host_regs
// Brief   : Host register file and command sequencer for the SHA-256 / XMSS core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256xmss_host_regs (
  input  wire logic                  io_mainClk,
  input  wire logic                  io_systemReset,
  sha256xmss_host_regs_if.slave      bus,
  output logic [2:0]                 cmd_reg,
  output logic [1023:0]              input_data_reg,
  output logic                       sha256XMSS_start_reg,
  output logic                       sha256XMSS_init_iv,
  output logic                       sha256XMSS_store_intermediate,
  output logic                       sha256XMSS_continue_intermediate,
  output logic                       sha256XMSS_message_length,
  output logic                       sha256XMSS_second_block_data_available,
  output logic                       sha256_sha256_start_reg,
  output logic                       sha256_sha256_init_message,
  output logic                       sha256_sha256_init_iv,
  input  wire logic                  sha256XMSS_done,
  input  wire logic [255:0]          output_data,
  input  wire logic                  module_busy,
  output logic                       irq
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam logic [2:0] CMD_SHA  = 3'b001;
  localparam logic [2:0] CMD_XMSS = 3'b010;
  localparam logic [7:0] TMO_LAST = 8'd254;

  state_t       state_q;
  logic [7:0]   tmo_cnt_q;
  logic         go_q;
  logic [31:0]  data_q   [32];
  logic [31:0]  result_q [8];
  logic [5:0]   cmd_q;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         rvalid_q;

  logic wr, rd, fsm_busy;
  logic wr_data, wr_cmd, wr_ctrl, wr_status, rd_status;
  logic busy_viol, cmd_valid, ctrl_ok, ctrl_bad, go_accept;
  logic is_xmss, xmss_done_hit, tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_data_out
      assign input_data_reg[1023-32*gi -: 32] = data_q[gi];
    end
  endgenerate

  assign cmd_reg                                = cmd_q[2:0];
  assign sha256XMSS_message_length              = cmd_q[3];
  assign sha256XMSS_second_block_data_available = cmd_q[4];
  assign irq                                    = done_q & cmd_q[5];
  assign bus.bus_rdata                          = rdata_q;
  assign bus.bus_rvalid                         = rvalid_q;

  always_comb begin
    wr        = bus.bus_sel & bus.bus_we;
    rd        = bus.bus_sel & ~bus.bus_we;
    fsm_busy  = (state_q != ST_IDLE);
    wr_data   = wr & ~bus.bus_addr[5];
    wr_cmd    = wr & (bus.bus_addr == 6'h20);
    wr_ctrl   = wr & (bus.bus_addr == 6'h21);
    wr_status = wr & (bus.bus_addr == 6'h22);
    rd_status = rd & (bus.bus_addr == 6'h22);
    busy_viol = fsm_busy & (wr_data | wr_cmd | wr_ctrl);
    cmd_valid = (cmd_q[2:0] == CMD_SHA) | (cmd_q[2:0] == CMD_XMSS);
    ctrl_ok   = wr_ctrl & ~fsm_busy & cmd_valid;
    ctrl_bad  = wr_ctrl & ~fsm_busy & ~cmd_valid;
    go_accept = ctrl_ok & bus.bus_wdata[0];
    is_xmss       = (cmd_q[2:0] == CMD_XMSS);
    xmss_done_hit = is_xmss & sha256XMSS_done;
    tmo_hit   = (state_q == ST_WAIT_HI) & ~xmss_done_hit & ~module_busy
              & (tmo_cnt_q == TMO_LAST);
    // Sticky bits: a set in the same cycle as a clear wins.
    done_d = (state_q == ST_CAPTURE) | (done_q & ~(rd_status | go_accept));
    err_d  = ctrl_bad | busy_viol | tmo_hit | (err_q & ~(wr_status & bus.bus_wdata[2]));

    rdata_d = 32'h0;
    if (!bus.bus_addr[5])
      rdata_d = data_q[bus.bus_addr[4:0]];
    else if (bus.bus_addr == 6'h20)
      rdata_d = {26'h0, cmd_q};
    else if (bus.bus_addr == 6'h22)
      rdata_d = {28'h0, module_busy, err_q, done_q, fsm_busy};
    else if (bus.bus_addr[5:3] == 3'b101)
      rdata_d = result_q[bus.bus_addr[2:0]];
  end

  always_ff @(posedge io_mainClk) begin
    if (io_systemReset) begin
      for (int i = 0; i < 32; i++) data_q[i] <= 32'h0;
      for (int j = 0; j < 8; j++)  result_q[j] <= 32'h0;
      cmd_q    <= 6'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_data && !fsm_busy) data_q[bus.bus_addr[4:0]] <= bus.bus_wdata;
      if (wr_cmd && !fsm_busy)  cmd_q <= bus.bus_wdata[5:0];
      if (state_q == ST_CAPTURE)
        for (int j = 0; j < 8; j++) result_q[j] <= output_data[255-32*j -: 32];
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rd;
      rdata_q  <= rd ? rdata_d : 32'h0;
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (io_systemReset) begin
      state_q                          <= ST_IDLE;
      tmo_cnt_q                        <= 8'h0;
      go_q                             <= 1'b0;
      sha256XMSS_start_reg             <= 1'b0;
      sha256XMSS_init_iv               <= 1'b0;
      sha256XMSS_store_intermediate    <= 1'b0;
      sha256XMSS_continue_intermediate <= 1'b0;
      sha256_sha256_start_reg          <= 1'b0;
      sha256_sha256_init_message       <= 1'b0;
      sha256_sha256_init_iv            <= 1'b0;
    end else begin
      // Pulses are registered on entry to ISSUE so they are high only during it.
      sha256XMSS_start_reg             <= 1'b0;
      sha256XMSS_init_iv               <= 1'b0;
      sha256XMSS_store_intermediate    <= 1'b0;
      sha256XMSS_continue_intermediate <= 1'b0;
      sha256_sha256_start_reg          <= 1'b0;
      sha256_sha256_init_message       <= 1'b0;
      sha256_sha256_init_iv            <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_ok) begin
            state_q <= ST_ISSUE;
            go_q    <= bus.bus_wdata[0];
            if (is_xmss) begin
              sha256XMSS_start_reg             <= bus.bus_wdata[0];
              sha256XMSS_init_iv               <= bus.bus_wdata[1];
              sha256XMSS_store_intermediate    <= bus.bus_wdata[3];
              sha256XMSS_continue_intermediate <= bus.bus_wdata[4];
            end else begin
              sha256_sha256_start_reg    <= bus.bus_wdata[0];
              sha256_sha256_init_iv      <= bus.bus_wdata[1];
              sha256_sha256_init_message <= bus.bus_wdata[2];
            end
          end
        end
        ST_ISSUE: begin
          tmo_cnt_q <= 8'h0;
          state_q   <= go_q ? ST_WAIT_HI : ST_IDLE;
        end
        ST_WAIT_HI: begin
          if (xmss_done_hit)                 state_q <= ST_CAPTURE;
          else if (module_busy)              state_q <= ST_WAIT_LO;
          else if (tmo_cnt_q == TMO_LAST)    state_q <= ST_IDLE;
          else                               tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
        ST_WAIT_LO: begin
          if (is_xmss ? sha256XMSS_done : !module_busy) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256xmss_host_regs.sv
//------------------------------------------------------------------------------
// Module  : tb_sha256xmss_host_regs
// Brief   : Directed self-checking bench for sha256xmss_host_regs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sha256xmss_host_regs;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cmd_reg;
  logic [1023:0] in_data;
  logic          x_start, x_iv, x_store, x_cont, x_len, x_sbd;
  logic          s_start, s_msg, s_iv;
  logic          core_done = 1'b0;
  logic [255:0]  out_data = '0;
  logic          core_busy = 1'b0;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] dig_a = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  logic [255:0] dig_b = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  logic [31:0]  rd_val;

  sha256xmss_host_regs_if bus_if ();

  sha256xmss_host_regs dut (
    .io_mainClk                             (clk),
    .io_systemReset                         (rst),
    .bus                                    (bus_if.slave),
    .cmd_reg                                (cmd_reg),
    .input_data_reg                         (in_data),
    .sha256XMSS_start_reg                   (x_start),
    .sha256XMSS_init_iv                     (x_iv),
    .sha256XMSS_store_intermediate          (x_store),
    .sha256XMSS_continue_intermediate       (x_cont),
    .sha256XMSS_message_length              (x_len),
    .sha256XMSS_second_block_data_available (x_sbd),
    .sha256_sha256_start_reg                (s_start),
    .sha256_sha256_init_message             (s_msg),
    .sha256_sha256_init_iv                  (s_iv),
    .sha256XMSS_done                        (core_done),
    .output_data                            (out_data),
    .module_busy                            (core_busy),
    .irq                                    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1;
    bus_if.bus_addr = a;   bus_if.bus_wdata = d;
    @(negedge clk);
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
  endtask

  // Returns one negedge after the accepting edge, when rdata/rvalid are valid.
  task automatic bus_read(input string tag, input logic [5:0] a, output logic [31:0] d);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = a;
    @(negedge clk);
    bus_if.bus_sel = 1'b0;
    check({tag, "_rvalid"}, {255'h0, bus_if.bus_rvalid}, 256'h1);
    d = bus_if.bus_rdata;
  endtask

  function automatic logic [6:0] pulses();
    return {x_start, x_iv, x_store, x_cont, s_start, s_msg, s_iv};
  endfunction

  initial begin
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
    bus_if.bus_addr = '0;  bus_if.bus_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_irq", {255'h0, irq}, 256'h0);
    check("rst_pulses", {249'h0, pulses()}, 256'h0);
    bus_read("rst_cmd", 6'h20, rd_val);    check("rst_cmd", {224'h0, rd_val}, 256'h0);
    bus_read("rst_status", 6'h22, rd_val); check("rst_status", {224'h0, rd_val}, 256'h0);
    bus_read("rst_res0", 6'h28, rd_val);   check("rst_res0", {224'h0, rd_val}, 256'h0);

    // XMSS flow
    bus_write(6'h00, 32'h61626380);
    bus_write(6'h05, 32'h00000055);
    bus_write(6'h20, 32'h0000002A);
    check("data0_port", {224'h0, in_data[1023:992]}, {224'h0, 32'h61626380});
    check("xmss_cmd_reg", {253'h0, cmd_reg}, 256'h2);
    check("xmss_len", {254'h0, x_len, x_sbd}, 256'h2);
    bus_write(6'h21, 32'h00000003);
    check("xmss_pulse", {249'h0, pulses()}, {249'h0, 7'b1100000});
    core_busy = 1'b1;
    @(negedge clk);
    check("xmss_pulse_end", {249'h0, pulses()}, 256'h0);
    repeat (63) @(negedge clk);
    core_busy = 1'b0; core_done = 1'b1; out_data = dig_a;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check("xmss_irq", {255'h0, irq}, 256'h1);
    for (int j = 0; j < 8; j++) begin
      bus_read("xmss_res", 6'h28 + 6'(j), rd_val);
      check("xmss_res", {224'h0, rd_val}, {224'h0, dig_a[255-32*j -: 32]});
    end
    bus_read("xmss_status", 6'h22, rd_val); check("xmss_status", {224'h0, rd_val}, 256'h2);
    check("xmss_irq_clr", {255'h0, irq}, 256'h0);

    // Plain SHA-256 flow
    out_data = dig_b;
    bus_write(6'h20, 32'h00000021);
    bus_write(6'h21, 32'h00000007);
    check("sha_pulse", {249'h0, pulses()}, {249'h0, 7'b0000111});
    core_busy = 1'b1;
    repeat (65) @(negedge clk);
    core_busy = 1'b0;
    @(negedge clk);
    check("sha_irq_capture", {255'h0, irq}, 256'h0);
    @(negedge clk);
    check("sha_irq_done", {255'h0, irq}, 256'h1);
    bus_read("sha_status", 6'h22, rd_val); check("sha_status", {224'h0, rd_val}, 256'h2);
    bus_read("sha_res0", 6'h28, rd_val);   check("sha_res0", {224'h0, rd_val}, {224'h0, dig_b[255:224]});
    bus_read("sha_res7", 6'h2F, rd_val);   check("sha_res7", {224'h0, rd_val}, {224'h0, dig_b[31:0]});

    // Unsupported command
    bus_write(6'h20, 32'h00000003);
    bus_write(6'h21, 32'h00000001);
    check("bad_pulse", {249'h0, pulses()}, 256'h0);
    bus_read("bad_status", 6'h22, rd_val); check("bad_status", {224'h0, rd_val}, 256'h4);
    bus_write(6'h22, 32'h00000004);
    bus_read("err_clr", 6'h22, rd_val);    check("err_clr", {224'h0, rd_val}, 256'h0);

    // Write while busy, then timeout with busy never rising
    bus_write(6'h20, 32'h00000002);
    bus_write(6'h21, 32'h00000001);
    check("tmo_pulse", {249'h0, pulses()}, {249'h0, 7'b1000000});
    bus_write(6'h05, 32'hDEADBEEF);
    bus_read("busy_wr_status", 6'h22, rd_val); check("busy_wr_status", {224'h0, rd_val}, 256'h5);
    bus_write(6'h22, 32'h00000004);
    bus_read("busy_err_clr", 6'h22, rd_val);   check("busy_err_clr", {224'h0, rd_val}, 256'h1);
    repeat (200) @(negedge clk);
    bus_read("tmo_wait", 6'h22, rd_val);       check("tmo_wait", {224'h0, rd_val}, 256'h1);
    repeat (60) @(negedge clk);
    bus_read("tmo_expired", 6'h22, rd_val);    check("tmo_expired", {224'h0, rd_val}, 256'h4);
    bus_read("data5_kept", 6'h05, rd_val);     check("data5_kept", {224'h0, rd_val}, 256'h55);
    bus_write(6'h22, 32'h00000004);

    // Reset while waiting for busy to fall
    bus_write(6'h20, 32'h0000003A);
    bus_write(6'h21, 32'h00000001);
    core_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; core_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pulses", {249'h0, pulses()}, 256'h0);
    check("mid_rst_outs", {251'h0, irq, x_len, x_sbd, bus_if.bus_rvalid, |bus_if.bus_rdata}, 256'h0);
    check("mid_rst_cmd", {253'h0, cmd_reg}, 256'h0);
    check("mid_rst_data", in_data[1023:768], 256'h0);
    bus_read("mid_rst_status", 6'h22, rd_val); check("mid_rst_status", {224'h0, rd_val}, 256'h0);
    bus_read("mid_rst_res0", 6'h28, rd_val);   check("mid_rst_res0", {224'h0, rd_val}, 256'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
